// File: rtl/debug_unit_loader.sv
// Host command decoder in front of the MIPS debug unit: loads program words, runs/steps the pipeline
// and answers every command with one status byte. Outputs are registered; UART tx waits on i_tx_busy.
module debug_unit_loader #(
  parameter int NB_REG   = 32,
  parameter int NB_DATA  = 8,
  parameter int NB_WIDHT = 9
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_busy,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_halt,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_reset_pc,
  output logic               o_dunit_w_en,
  output logic [NB_REG-1:0]  o_dunit_mem_addr,
  output logic [NB_REG-1:0]  o_dunit_mem_data
);

  localparam int BYTES_PER_WORD = NB_REG / NB_DATA;
  localparam int BC_W           = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [NB_REG-1:0] MAX_WORDS = NB_REG'((1 << NB_WIDHT) / 4);

  localparam logic [NB_DATA-1:0] CMD_LOAD  = NB_DATA'(8'h4C);
  localparam logic [NB_DATA-1:0] CMD_CONT  = NB_DATA'(8'h43);
  localparam logic [NB_DATA-1:0] CMD_STEP  = NB_DATA'(8'h53);
  localparam logic [NB_DATA-1:0] CMD_RSTPC = NB_DATA'(8'h52);
  localparam logic [NB_DATA-1:0] CMD_PAUSE = NB_DATA'(8'h50);
  localparam logic [NB_DATA-1:0] RSP_ACK   = NB_DATA'(8'h06);
  localparam logic [NB_DATA-1:0] RSP_NAK   = NB_DATA'(8'h15);
  localparam logic [NB_DATA-1:0] RSP_HALT  = NB_DATA'(8'h48);

  typedef enum logic [2:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WRITE, RUN, STEP, RST_PC, SEND
  } state_t;

  state_t             state_q;
  logic [NB_REG-1:0]  word_cnt_q;
  logic [NB_REG-1:0]  word_idx_q;
  logic [NB_REG-1:0]  asm_q;
  logic [BC_W-1:0]    byte_cnt_q;
  logic [NB_REG-1:0]  mem_addr_q;
  logic [NB_REG-1:0]  mem_data_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               clk_en_q;
  logic               reset_pc_q;
  logic               w_en_q;

  logic [NB_REG-1:0]  asm_d;
  logic [NB_REG-1:0]  addr_d;
  logic [NB_REG-1:0]  rx_ext;
  logic               rx_pause;
  logic               last_word;

  // Bytes arrive big-endian, so each new byte lands in the low lane.
  assign asm_d     = {asm_q[NB_REG-NB_DATA-1:0], i_rx_data};
  assign addr_d    = word_idx_q << 2;
  assign rx_ext    = NB_REG'(i_rx_data);
  assign rx_pause  = i_rx_valid && (i_rx_data == CMD_PAUSE);
  assign last_word = (word_idx_q + NB_REG'(1)) == word_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      word_idx_q <= '0;
      asm_q      <= '0;
      byte_cnt_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      clk_en_q   <= 1'b0;
      reset_pc_q <= 1'b0;
      w_en_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      reset_pc_q <= 1'b0;
      w_en_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: state_q <= LD_CNT;
              CMD_CONT: begin
                clk_en_q <= 1'b1;
                state_q  <= RUN;
              end
              CMD_STEP: begin
                // A pipeline that already halted is not clocked again.
                if (i_halt) begin
                  tx_data_q <= RSP_HALT;
                  state_q   <= SEND;
                end else begin
                  clk_en_q <= 1'b1;
                  state_q  <= STEP;
                end
              end
              CMD_RSTPC: begin
                reset_pc_q <= 1'b1;
                state_q    <= RST_PC;
              end
              default: begin
                tx_data_q <= RSP_NAK;
                state_q   <= SEND;
              end
            endcase
          end
        end
        LD_CNT: begin
          if (i_rx_valid) begin
            if (rx_ext == '0) begin
              tx_data_q <= RSP_ACK;
              state_q   <= SEND;
            end else if (rx_ext > MAX_WORDS) begin
              tx_data_q <= RSP_NAK;
              state_q   <= SEND;
            end else begin
              word_cnt_q <= rx_ext;
              word_idx_q <= '0;
              byte_cnt_q <= '0;
              state_q    <= LD_BYTE;
            end
          end
        end
        LD_BYTE: begin
          if (i_rx_valid) begin
            asm_q <= asm_d;
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q <= '0;
              w_en_q     <= 1'b1;
              mem_addr_q <= addr_d;
              mem_data_q <= asm_d;
              state_q    <= LD_WRITE;
            end else begin
              byte_cnt_q <= byte_cnt_q + BC_W'(1);
            end
          end
        end
        LD_WRITE: begin
          word_idx_q <= word_idx_q + NB_REG'(1);
          // A byte landing on the write cycle already belongs to the next word.
          if (i_rx_valid) begin
            asm_q      <= asm_d;
            byte_cnt_q <= BC_W'(1);
          end
          if (last_word) begin
            reset_pc_q <= 1'b1;
            state_q    <= RST_PC;
          end else begin
            state_q <= LD_BYTE;
          end
        end
        RUN: begin
          if (i_halt || rx_pause) begin
            clk_en_q  <= 1'b0;
            tx_data_q <= RSP_HALT;
            state_q   <= SEND;
          end
        end
        STEP: begin
          clk_en_q  <= 1'b0;
          tx_data_q <= RSP_ACK;
          state_q   <= SEND;
        end
        RST_PC: begin
          tx_data_q <= RSP_ACK;
          state_q   <= SEND;
        end
        SEND: begin
          if (!i_tx_busy) begin
            tx_start_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data        = tx_data_q;
  assign o_tx_start       = tx_start_q;
  assign o_dunit_clk_en   = clk_en_q;
  assign o_dunit_reset_pc = reset_pc_q;
  assign o_dunit_w_en     = w_en_q;
  assign o_dunit_mem_addr = mem_addr_q;
  assign o_dunit_mem_data = mem_data_q;

endmodule

// File: tb/tb_debug_unit_loader.sv
// Randomized command streams against a transaction-level model of the loader's responses.
module tb_debug_unit_loader;

  localparam int NB_REG   = 32;
  localparam int NB_DATA  = 8;
  localparam int NB_WIDHT = 9;
  localparam int MAXW     = (1 << NB_WIDHT) / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic        halt;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        clk_en;
  logic        reset_pc;
  logic        w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_unit_loader #(.NB_REG(NB_REG), .NB_DATA(NB_DATA), .NB_WIDHT(NB_WIDHT)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_tx_busy(tx_busy), .o_tx_data(tx_data), .o_tx_start(tx_start), .i_halt(halt),
    .o_dunit_clk_en(clk_en), .o_dunit_reset_pc(reset_pc), .o_dunit_w_en(w_en),
    .o_dunit_mem_addr(mem_addr), .o_dunit_mem_data(mem_data)
  );

  // Observed transactions, gathered on the falling edge.
  logic [63:0] wr_q[$];
  logic [7:0]  tx_q[$];
  int          clk_cnt = 0, rpc_cnt = 0, cyc = 0, tx_cyc = 0, busy_viol = 0;
  logic        busy_e = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_e <= tx_busy;
  end

  always @(negedge clk) begin
    if (w_en) wr_q.push_back({mem_addr, mem_data});
    if (tx_start) begin
      tx_q.push_back(tx_data);
      tx_cyc = cyc;
      if (busy_e) busy_viol++;
    end
    if (clk_en) clk_cnt++;
    if (reset_pc) rpc_cnt++;
  end

  // Expected writes for the command under test.
  logic [63:0] exp_wr[$];
  logic [31:0] ld_words[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    tx_q.delete();
    exp_wr.delete();
    clk_cnt = 0;
    rpc_cnt = 0;
  endtask

  task automatic wait_tx(input int busy_cycles);
    int n = 0;
    int drop_cyc = -1;
    while (tx_q.size() == 0 && n < 400) begin
      if (n == busy_cycles && tx_busy) begin
        tx_busy  = 1'b0;
        drop_cyc = cyc;
      end
      @(negedge clk);
      n++;
    end
    tx_busy = 1'b0;
    idle(3);
    chk("tx_timeout", 64'(tx_q.size() != 0), 64'd1);
    if (drop_cyc >= 0 && busy_cycles >= 4)
      chk("tx_after_busy", 64'(tx_cyc - drop_cyc), 64'd1);
  endtask

  task automatic compare(input string tag, input logic [7:0] exp_tx, input int exp_clk,
                         input int exp_rpc);
    chk({tag, "_ntx"}, 64'(tx_q.size()), 64'd1);
    if (tx_q.size() > 0) chk({tag, "_tx"}, 64'(tx_q[0]), 64'(exp_tx));
    chk({tag, "_clk"}, 64'(clk_cnt), 64'(exp_clk));
    chk({tag, "_rpc"}, 64'(rpc_cnt), 64'(exp_rpc));
    chk({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      chk({tag, "_wr"}, wr_q[i], exp_wr[i]);
    clear_mon();
  endtask

  task automatic fill_words(input int n);
    ld_words.delete();
    for (int i = 0; i < n; i++) ld_words.push_back($urandom);
  endtask

  // Model: a valid load writes word i at byte address 4*i, pulses reset_pc once and ACKs.
  task automatic do_load(input int n, input int gapmax, input int busy);
    logic [31:0] w;
    tx_busy = (busy > 0);
    send_byte(8'h4C);
    idle($urandom_range(0, gapmax));
    send_byte(8'(n));
    if (n > 0 && n <= MAXW) begin
      for (int i = 0; i < n; i++) begin
        w = ld_words[i];
        exp_wr.push_back({32'(i * 4), w});
        for (int b = 3; b >= 0; b--) begin
          idle($urandom_range(0, gapmax));
          send_byte(w[8*b +: 8]);
        end
      end
    end
    wait_tx(busy);
    if (n == 0)         compare("load_zero", 8'h06, 0, 0);
    else if (n > MAXW)  compare("load_big", 8'h15, 0, 0);
    else                compare("load", 8'h06, 0, 1);
  endtask

  task automatic do_step(input bit h, input int busy);
    halt    = h;
    tx_busy = (busy > 0);
    send_byte(8'h53);
    wait_tx(busy);
    halt = 1'b0;
    compare("step", h ? 8'h48 : 8'h06, h ? 0 : 1, 0);
  endtask

  // mode 0: halt, 1: 'P', 2: both at once. Pipeline must be clocked exactly k cycles.
  task automatic do_run(input int k, input int mode, input int busy);
    logic [7:0] j;
    tx_busy = (busy > 0);
    send_byte(8'h43);
    for (int c = 1; c < k; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom);
        if (j == 8'h50) j = 8'h51;
        rx_data  = j;
        rx_valid = 1'b1;
      end
      @(negedge clk);
      rx_valid = 1'b0;
    end
    if (mode != 1) halt = 1'b1;
    if (mode != 0) send_byte(8'h50);
    wait_tx(busy);
    halt = 1'b0;
    compare("run", 8'h48, k, 0);
  endtask

  task automatic do_single(input logic [7:0] b, input int busy);
    tx_busy = (busy > 0);
    send_byte(b);
    wait_tx(busy);
    if (b == 8'h52) compare("rstpc", 8'h06, 0, 1);
    else            compare("bad_cmd", 8'h15, 0, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_w_en"}, 64'(w_en), 64'd0);
    chk({tag, "_clk_en"}, 64'(clk_en), 64'd0);
    chk({tag, "_reset_pc"}, 64'(reset_pc), 64'd0);
    chk({tag, "_tx_start"}, 64'(tx_start), 64'd0);
    chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_data"}, 64'(mem_data), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    int kind;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_busy = 1'b0; halt = 1'b0;
    idle(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // Reset in the middle of a two-word load; the first word is already written.
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    idle(2);
    chk("midload_nwr", 64'(wr_q.size()), 64'd1);
    if (wr_q.size() > 0) chk("midload_wr", wr_q[0], 64'h00000000_20080005);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    clear_mon();
    do_step(1'b0, 0);

    // Reference program, then the same load back-to-back.
    ld_words.delete();
    ld_words.push_back(32'h20080005);
    ld_words.push_back(32'h00000000);
    do_load(2, 2, 0);
    fill_words(2);
    do_load(2, 0, 0);

    do_step(1'b0, 10);
    do_step(1'b1, 0);
    do_run(20, 0, 0);
    do_run(20, 1, 0);
    do_run(5, 2, 3);

    do_single(8'h7A, 0);
    do_single(8'h52, 5);
    do_load(129, 1, 0);
    do_load(0, 1, 0);
    fill_words(MAXW);
    do_load(MAXW, 0, 0);

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          fill_words($urandom_range(1, 4));
          do_load(ld_words.size(), $urandom_range(0, 2), $urandom_range(0, 6));
        end
        1: do_load(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXW + 1, 255), 1,
                   $urandom_range(0, 6));
        2: do_step(1'($urandom_range(0, 1)), $urandom_range(0, 6));
        3: do_run($urandom_range(1, 25), $urandom_range(0, 2), $urandom_range(0, 6));
        4: do_single(8'h52, $urandom_range(0, 6));
        default: begin
          b = 8'($urandom);
          while (b == 8'h4C || b == 8'h43 || b == 8'h53 || b == 8'h52) b = 8'($urandom);
          do_single(b, $urandom_range(0, 6));
        end
      endcase
    end

    chk("tx_while_busy", 64'(busy_viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_unit_loader.md
Name: debug_unit_loader

Overview:
- Host-side control stage directly upstream of the 5-stage MIPS pipeline top.
- Consumes bytes from an external UART receiver and decodes host commands.
- Drives the pipeline's debug-unit inputs: clock enable, PC reset, instruction-memory write enable/address/data.
- Returns one status byte per command through an external UART transmitter.

Parameters:
- NB_REG, 32, width of instruction word and memory address/data buses.
- NB_DATA, 8, UART byte width.
- NB_WIDHT, 9, instruction-memory byte-address width; max program = 2^NB_WIDHT/4 words (128 at default).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  NB_DATA  received UART byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid.
- i_tx_busy  in  1  UART transmitter busy.
- o_tx_data  out  NB_DATA  byte to transmit.
- o_tx_start  out  1  one-cycle transmit request.
- i_halt  in  1  pipeline has retired a HALT instruction; level signal.
- o_dunit_clk_en  out  1  pipeline clock enable.
- o_dunit_reset_pc  out  1  PC reset pulse.
- o_dunit_w_en  out  1  instruction-memory write enable.
- o_dunit_mem_addr  out  NB_REG  instruction-memory byte address.
- o_dunit_mem_data  out  NB_REG  instruction-memory write data.

Behaviour:
Reset
- On i_reset: all outputs 0; FSM in IDLE; byte and word counters 0; assembly register 0.
- Reset asserted mid-operation aborts immediately to IDLE.
- Words already written to memory are not undone.

FSM states: IDLE, LD_CNT, LD_BYTE, LD_WRITE, RUN, STEP, RST_PC, SEND.
- o_dunit_clk_en is 1 only in RUN and in the single STEP cycle; 0 everywhere else.

IDLE: on i_rx_valid, decode i_rx_data.
- 0x4C 'L' -> LD_CNT.
- 0x43 'C' -> RUN.
- 0x53 'S' -> STEP.
- 0x52 'R' -> RST_PC.
- Any other byte -> SEND with 0x15 (NAK).

LD_CNT: next valid byte is word count N.
- N=0 -> SEND 0x06 (ACK); nothing written.
- N > 2^NB_WIDHT/4 -> SEND 0x15.
- Otherwise latch N, clear word index and byte counter, go to LD_BYTE.

LD_BYTE: each valid byte shifts into the assembly register, MSB first (big-endian).
- After the 4th byte -> LD_WRITE.

LD_WRITE: single cycle.
- o_dunit_w_en=1, o_dunit_mem_addr = word_index*4 (zero-extended), o_dunit_mem_data = assembled word.
- Next cycle: w_en=0, word_index increments.
- If word_index+1==N -> RST_PC; else back to LD_BYTE.
- An i_rx_valid arriving during LD_WRITE is captured as byte 0 of the next word; bytes are never dropped.

RST_PC: o_dunit_reset_pc=1 for exactly one cycle, then SEND 0x06.

RUN:
- clk_en=1 every cycle.
- Exit to SEND 0x48 ('H'), with clk_en=0 in the same cycle the transition is registered, when either:
  - i_halt=1, or
  - a valid byte 0x50 ('P') is received.
- Other bytes received in RUN are ignored.
- If i_halt and 'P' occur in the same cycle, send 0x48 once.

STEP:
- clk_en=1 for exactly one cycle.
- Then SEND 0x06, or 0x48 if i_halt is already 1 on entry; in that case clk_en stays 0 and no step is taken.

SEND:
- Holds the pending byte in o_tx_data.
- On the first cycle with i_tx_busy=0, pulse o_tx_start for one cycle, then return to IDLE.
- i_rx_valid during SEND is ignored.

Latency and timing
- Command byte to first action: 1 cycle.
- The 4th data byte to the w_en pulse: 1 cycle.
- All outputs are registered.

Test Plan:
- Reset mid-load: send 0x4C,0x02, then 4 bytes, then pulse i_reset -> outputs 0, state IDLE; the next 0x53 steps normally and returns 0x06.
- Load: send 0x4C,0x02,0x20,0x08,0x00,0x05,0x00,0x00,0x00,0x00 ->
  - w_en pulse with addr 0x0, data 0x20080005;
  - w_en pulse with addr 0x4, data 0x00000000;
  - one reset_pc pulse, then tx 0x06;
  - clk_en stays 0 throughout.
- Back-to-back bytes (i_rx_valid every cycle) during load -> both words written correctly; no byte lost across LD_WRITE.
- Step and tx backpressure: send 0x53 with i_tx_busy=1 for 10 cycles -> clk_en high exactly 1 cycle; tx_start fires on the first cycle busy=0, with o_tx_data=0x06.
- Run: send 0x43, assert i_halt after 20 cycles -> clk_en high for exactly those 20 cycles, then 0; tx 0x48 once. Repeat with 'P' instead of i_halt -> same response.
- Errors:
  - Send 0x7A -> tx 0x15.
  - Send 0x4C,0x81 (129 > 128) -> tx 0x15; no w_en.
  - Send 0x4C,0x00 -> tx 0x06; no w_en; no reset_pc.
